// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/grant_decoder2to4.sv
// rtl/grant_decoder2to4.sv - 2-to-4 one-hot decoder with enable
module grant_decoder2to4 (
  input  logic e,
  input  logic x0,
  input  logic x1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = e & ~x1 & ~x0;
  assign y1 = e & ~x1 &  x0;
  assign y2 = e &  x1 & ~x0;
  assign y3 = e &  x1 &  x0;

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with optional hold limit
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid
);

  localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       hold_q, hold_d;

  logic [N_REQ-1:0] others;
  logic [IDX_W-1:0] next_ptr;
  logic             release_ev;

  // First set bit of mask scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] mask,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (mask[idx]) pick = idx;
    end
  endfunction

  assign others     = req & ~(N_REQ'(1) << owner_q);
  assign next_ptr   = owner_q + IDX_W'(1);
  assign release_ev = ~req[owner_q] | (HOLD_EN && (hold_q == HOLD_LIM));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d = ST_BUSY;
        owner_d = pick(req, ptr_q);
        hold_d  = 8'd1;
      end
    end else if (!release_ev) begin
      if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
    end else begin
      ptr_d = next_ptr;
      if (|others) begin
        owner_d = pick(others, next_ptr);
        hold_d  = 8'd1;
      end else if (req[owner_q]) begin
        // lone requester hit the hold limit: re-grant without a gap
        hold_d = 8'd1;
      end else begin
        state_d = ST_IDLE;
        owner_d = '0;
        hold_d  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  // owner_q is cleared whenever the arbiter goes idle, so gnt_id reads 0 then
  assign gnt_valid = (state_q == ST_BUSY);
  assign gnt_id    = owner_q;

  grant_decoder2to4 u_dec (
    .e  (gnt_valid),
    .x0 (owner_q[0]),
    .x1 (owner_q[1]),
    .y0 (gnt[0]),
    .y1 (gnt[1]),
    .y2 (gnt[2]),
    .y3 (gnt[3])
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4 at hold limits 8, 3 and 0
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_w [3];
  logic [1:0] id_w  [3];
  logic       gv_w  [3];

  int n_checks = 0;
  int n_pass   = 0;

  int mh      [3] = '{8, 3, 0};
  int m_busy  [3];
  int m_owner [3];
  int m_ptr   [3];
  int m_cnt   [3];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_valid(gv_w[0]));
  rr_arbiter4 #(.MAX_HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_valid(gv_w[1]));
  rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[2]), .gnt_id(id_w[2]), .gnt_valid(gv_w[2]));

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int pick_m(input int mask, input int p);
    for (int k = 0; k < 4; k++)
      if (((mask >> ((p + k) % 4)) & 1) == 1) return (p + k) % 4;
    return 0;
  endfunction

  task automatic model_step(input int rs, input int r);
    int others;
    bit rel;
    for (int n = 0; n < 3; n++) begin
      if (rs != 0) begin
        m_busy[n] = 0; m_owner[n] = 0; m_ptr[n] = 0; m_cnt[n] = 0;
      end else if (m_busy[n] == 0) begin
        if (r != 0) begin
          m_busy[n] = 1; m_owner[n] = pick_m(r, m_ptr[n]); m_cnt[n] = 1;
        end
      end else begin
        rel = (((r >> m_owner[n]) & 1) == 0) || (mh[n] != 0 && m_cnt[n] == mh[n]);
        if (!rel) begin
          m_cnt[n] = (m_cnt[n] < 255) ? m_cnt[n] + 1 : 255;
        end else begin
          m_ptr[n] = (m_owner[n] + 1) % 4;
          others   = r & ~(1 << m_owner[n]);
          if (others != 0) begin
            m_owner[n] = pick_m(others, m_ptr[n]); m_cnt[n] = 1;
          end else if (((r >> m_owner[n]) & 1) == 1) begin
            m_cnt[n] = 1;
          end else begin
            m_busy[n] = 0; m_owner[n] = 0; m_cnt[n] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(int'(rs), int'(r));
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("gnt[%0d]", n), int'(gnt_w[n]), m_busy[n] != 0 ? (1 << m_owner[n]) : 0);
      chk($sformatf("gnt_id[%0d]", n), int'(id_w[n]), m_busy[n] != 0 ? m_owner[n] : 0);
      chk($sformatf("gnt_valid[%0d]", n), int'(gv_w[n]), m_busy[n]);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       rs;
    @(negedge clk);

    // reset then idle
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("reset_gnt", int'(gnt_w[0]), 0);
    chk("reset_valid", int'(gv_w[0]), 0);
    chk("reset_id", int'(id_w[0]), 0);

    // single requester, then ptr must have moved to 3
    for (int i = 1; i <= 5; i++) begin
      step(4'b0100, 1'b0);
      chk("single_hold", int'(gnt_w[0]), 4'b0100);
    end
    step(4'b0000, 1'b0);
    chk("single_release", int'(gnt_w[0]), 0);
    step(4'b1111, 1'b0);
    chk("ptr_after_single", int'(gnt_w[0]), 4'b1000);

    // all requesting from reset, hold limit 8
    step(4'b0000, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      step(4'b1111, 1'b0);
      case (i)
        1, 8:   chk("all_req_0", int'(gnt_w[0]), 4'b0001);
        9, 16:  chk("all_req_1", int'(gnt_w[0]), 4'b0010);
        17, 24: chk("all_req_2", int'(gnt_w[0]), 4'b0100);
        25, 32: chk("all_req_3", int'(gnt_w[0]), 4'b1000);
        33:     chk("all_req_wrap", int'(gnt_w[0]), 4'b0001);
        default: ;
      endcase
    end

    // back-to-back handoff from owner 1 skips to 3
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    chk("handoff_owner1", int'(gnt_w[0]), 4'b0010);
    step(4'b1001, 1'b0);
    chk("handoff_gnt", int'(gnt_w[0]), 4'b1000);
    chk("handoff_valid", int'(gv_w[0]), 1);
    chk("handoff_id", int'(id_w[0]), 3);

    // lone requester across hold limit 3: no gap
    step(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, 1'b0);
      chk("timeout_gnt", int'(gnt_w[1]), 4'b0010);
      chk("timeout_valid", int'(gv_w[1]), 1);
    end

    // reset mid-grant
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    chk("mid_before", int'(gnt_w[0]), 4'b0100);
    step(4'b1111, 1'b1);
    chk("mid_reset", int'(gnt_w[0]), 0);
    step(4'b1111, 1'b0);
    chk("mid_after", int'(gnt_w[0]), 4'b0001);

    // randomized traffic with sticky requests and occasional reset
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 127) == 0);
      step(r, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
